// File: rtl/id_pipe.sv
// id_pipe: instruction decode stage with operand bypass and the ID/EX register.
//   clk, rst          : single clock, synchronous active-high reset
//   flush_i, stall_i  : pipeline control (flush loads a bubble, stall holds ID/EX)
//   inst_valid_i, pc_i, inst_i : instruction being decoded
//   reg1/2_data_i     : regfile read data; reg1/2_read_o, reg1/2_addr_o drive the reads
//   byp_*_i           : write-back bypass channels, channel 0 is youngest (wins)
//   stall_req_o       : load-use hazard request to fetch
//   *_o (registered)  : ID/EX register contents
module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int NUM_BYP = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      stall_i,
  input  logic                      inst_valid_i,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_BYP-1:0]        byp_wreg_i,
  input  logic [5*NUM_BYP-1:0]      byp_wd_i,
  input  logic [DATA_W*NUM_BYP-1:0] byp_wdata_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  output logic                      stall_req_o,
  output logic                      valid_o,
  output logic [31:0]               pc_o,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic                      is_load_o,
  output logic                      inst_invalid_o
);

  localparam logic [7:0] EXE_NOP_OP  = 8'h00, EXE_AND_OP  = 8'h24, EXE_OR_OP   = 8'h25,
                         EXE_XOR_OP  = 8'h26, EXE_NOR_OP  = 8'h27, EXE_SLL_OP  = 8'h7C,
                         EXE_SRL_OP  = 8'h02, EXE_SRA_OP  = 8'h03, EXE_SLLV_OP = 8'h04,
                         EXE_SRLV_OP = 8'h06, EXE_SRAV_OP = 8'h07, EXE_MOVZ_OP = 8'h0A,
                         EXE_MOVN_OP = 8'h0B, EXE_MFHI_OP = 8'h10, EXE_MTHI_OP = 8'h11,
                         EXE_MFLO_OP = 8'h12, EXE_MTLO_OP = 8'h13, EXE_LW_OP   = 8'hE3;
  localparam logic [2:0] EXE_RES_NOP = 3'd0, EXE_RES_LOGIC = 3'd1, EXE_RES_SHIFT = 3'd2,
                         EXE_RES_MOVE = 3'd3, EXE_RES_LOAD = 3'd7;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [4:0]        wd;
    logic              wreg;
    logic              is_load;
    logic              invalid;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  idex_t idex_q, idex_d, dec;

  logic [5:0]        op, func;
  logic [4:0]        rs, rt, rd;
  logic              rd1, rd2, is_movz, is_movn;
  logic [DATA_W-1:0] imm, op1, op2;

  assign op   = inst_i[31:26];
  assign rs   = inst_i[25:21];
  assign rt   = inst_i[20:16];
  assign rd   = inst_i[15:11];
  assign func = inst_i[5:0];

  // Decode. Nothing is enabled during reset or when no instruction is present,
  // which also keeps the hazard detector quiet in those cycles.
  always_comb begin
    dec     = BUBBLE;
    rd1     = 1'b0;
    rd2     = 1'b0;
    imm     = '0;
    is_movz = 1'b0;
    is_movn = 1'b0;
    if (!rst && inst_valid_i) begin
      dec.valid = 1'b1;
      dec.pc    = pc_i;
      dec.wd    = rd;
      case (op)
        6'b000000: begin
          case (func)
            6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
              rd1 = 1'b1; rd2 = 1'b1; dec.wreg = 1'b1; dec.alusel = EXE_RES_LOGIC;
              case (func[1:0])
                2'b00:   dec.aluop = EXE_AND_OP;
                2'b01:   dec.aluop = EXE_OR_OP;
                2'b10:   dec.aluop = EXE_XOR_OP;
                default: dec.aluop = EXE_NOR_OP;
              endcase
            end
            6'b000100, 6'b000110, 6'b000111: begin
              rd1 = 1'b1; rd2 = 1'b1; dec.wreg = 1'b1; dec.alusel = EXE_RES_SHIFT;
              dec.aluop = (func[1:0] == 2'b00) ? EXE_SLLV_OP :
                          (func[1:0] == 2'b10) ? EXE_SRLV_OP : EXE_SRAV_OP;
            end
            6'b000000, 6'b000010, 6'b000011: begin
              rd2 = 1'b1; dec.wreg = 1'b1; dec.alusel = EXE_RES_SHIFT;
              imm = DATA_W'(inst_i[10:6]);
              dec.aluop = (func[1:0] == 2'b00) ? EXE_SLL_OP :
                          (func[1:0] == 2'b10) ? EXE_SRL_OP : EXE_SRA_OP;
            end
            6'b010000, 6'b010010: begin
              dec.wreg = 1'b1; dec.alusel = EXE_RES_MOVE;
              dec.aluop = func[1] ? EXE_MFLO_OP : EXE_MFHI_OP;
            end
            6'b010001, 6'b010011: begin
              rd1 = 1'b1;
              dec.aluop = func[1] ? EXE_MTLO_OP : EXE_MTHI_OP;
            end
            6'b001010, 6'b001011: begin
              rd1 = 1'b1; rd2 = 1'b1; dec.alusel = EXE_RES_MOVE;
              is_movn = func[0];
              is_movz = !func[0];
              dec.aluop = func[0] ? EXE_MOVN_OP : EXE_MOVZ_OP;
            end
            6'b001111: ;  // SYNC: no write-back
            default: dec.invalid = 1'b1;
          endcase
        end
        6'b001100, 6'b001101, 6'b001110: begin
          rd1 = 1'b1; dec.wreg = 1'b1; dec.wd = rt; dec.alusel = EXE_RES_LOGIC;
          imm = DATA_W'(inst_i[15:0]);
          dec.aluop = (op[1:0] == 2'b00) ? EXE_AND_OP :
                      (op[1:0] == 2'b01) ? EXE_OR_OP : EXE_XOR_OP;
        end
        6'b001111: begin  // LUI evaluates as $rs | (imm << 16) with rs = $0
          rd1 = 1'b1; dec.wreg = 1'b1; dec.wd = rt; dec.alusel = EXE_RES_LOGIC;
          dec.aluop = EXE_OR_OP;
          imm = DATA_W'({inst_i[15:0], 16'h0000});
        end
        6'b100011: begin
          rd1 = 1'b1; dec.wreg = 1'b1; dec.wd = rt; dec.is_load = 1'b1;
          dec.aluop = EXE_LW_OP; dec.alusel = EXE_RES_LOAD;
          imm = DATA_W'($signed(inst_i[15:0]));
        end
        6'b110011: ;  // PREF: no write-back
        default: dec.invalid = 1'b1;
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] pick(input logic en, input logic [4:0] addr,
                                             input logic [DATA_W-1:0] rf,
                                             input logic [DATA_W-1:0] imm_v);
    logic hit;
    pick = rf;
    hit  = 1'b0;
    if (!en) begin
      pick = imm_v;
    end else if (addr == 5'd0) begin
      pick = '0;
    end else begin
      for (int i = 0; i < NUM_BYP; i++) begin
        if (!hit && byp_wreg_i[i] && byp_wd_i[5*i +: 5] == addr) begin
          pick = byp_wdata_i[DATA_W*i +: DATA_W];
          hit  = 1'b1;
        end
      end
    end
  endfunction

  assign op1 = pick(rd1, rs, reg1_data_i, imm);
  assign op2 = pick(rd2, rt, reg2_data_i, imm);

  assign reg1_read_o = rd1;
  assign reg2_read_o = rd2;
  assign reg1_addr_o = rst ? 5'd0 : rs;
  assign reg2_addr_o = rst ? 5'd0 : rt;

  assign stall_req_o = !rst && !stall_i && idex_q.valid && idex_q.is_load &&
                       (idex_q.wd != 5'd0) &&
                       ((rd1 && rs == idex_q.wd) || (rd2 && rt == idex_q.wd));

  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = BUBBLE;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (stall_req_o || !inst_valid_i) begin
      idex_d = BUBBLE;
    end else begin
      idex_d      = dec;
      idex_d.reg1 = op1;
      idex_d.reg2 = op2;
      // conditional moves resolve write-enable on the forwarded rt value
      if (is_movn) idex_d.wreg = (op2 != '0);
      if (is_movz) idex_d.wreg = (op2 == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= BUBBLE;
    else     idex_q <= idex_d;
  end

  assign valid_o        = idex_q.valid;
  assign pc_o           = idex_q.pc;
  assign aluop_o        = idex_q.aluop;
  assign alusel_o       = idex_q.alusel;
  assign reg1_o         = idex_q.reg1;
  assign reg2_o         = idex_q.reg2;
  assign wd_o           = idex_q.wd;
  assign wreg_o         = idex_q.wreg;
  assign is_load_o      = idex_q.is_load;
  assign inst_invalid_o = idex_q.invalid;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed checks of id_pipe at DATA_W=64/NUM_BYP=3 (main) and
// DATA_W=32/NUM_BYP=1 (narrow) driven from the same stimulus.
module tb_id_pipe;

  logic         clk = 1'b0;
  logic         rst, flush, stall, ivld;
  logic [31:0]  pc, inst;
  logic [63:0]  rd1_data, rd2_data;
  logic [2:0]   byp_we;
  logic [14:0]  byp_wd;
  logic [191:0] byp_wdata;

  logic        m_r1, m_r2, m_stl, m_vld, m_wreg, m_ld, m_inv;
  logic [4:0]  m_a1, m_a2, m_wd;
  logic [31:0] m_pc;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [63:0] m_reg1, m_reg2;

  logic        s_r1, s_r2, s_stl, s_vld, s_wreg, s_ld, s_inv;
  logic [4:0]  s_a1, s_a2, s_wd;
  logic [31:0] s_pc;
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1, s_reg2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_pipe #(.DATA_W(64), .NUM_BYP(3)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall), .inst_valid_i(ivld),
    .pc_i(pc), .inst_i(inst), .reg1_data_i(rd1_data), .reg2_data_i(rd2_data),
    .byp_wreg_i(byp_we), .byp_wd_i(byp_wd), .byp_wdata_i(byp_wdata),
    .reg1_read_o(m_r1), .reg2_read_o(m_r2), .reg1_addr_o(m_a1), .reg2_addr_o(m_a2),
    .stall_req_o(m_stl), .valid_o(m_vld), .pc_o(m_pc), .aluop_o(m_aluop),
    .alusel_o(m_alusel), .reg1_o(m_reg1), .reg2_o(m_reg2), .wd_o(m_wd),
    .wreg_o(m_wreg), .is_load_o(m_ld), .inst_invalid_o(m_inv));

  id_pipe #(.DATA_W(32), .NUM_BYP(1)) u_dut32 (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall), .inst_valid_i(ivld),
    .pc_i(pc), .inst_i(inst), .reg1_data_i(rd1_data[31:0]), .reg2_data_i(rd2_data[31:0]),
    .byp_wreg_i(byp_we[0:0]), .byp_wd_i(byp_wd[4:0]), .byp_wdata_i(byp_wdata[31:0]),
    .reg1_read_o(s_r1), .reg2_read_o(s_r2), .reg1_addr_o(s_a1), .reg2_addr_o(s_a2),
    .stall_req_o(s_stl), .valid_o(s_vld), .pc_o(s_pc), .aluop_o(s_aluop),
    .alusel_o(s_alusel), .reg1_o(s_reg1), .reg2_o(s_reg2), .wd_o(s_wd),
    .wreg_o(s_wreg), .is_load_o(s_ld), .inst_invalid_o(s_inv));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byp(input int ch, input logic [4:0] wd, input logic [63:0] data,
                         input logic we);
    byp_wd[5*ch +: 5]       = wd;
    byp_wdata[64*ch +: 64]  = data;
    byp_we[ch]              = we;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    inst = i;
    pc   = p;
    ivld = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; ivld = 1'b1;
    pc = 32'h0; inst = 32'h0021_1025;
    rd1_data = '0; rd2_data = '0;
    byp_we = '0; byp_wd = '0; byp_wdata = '0;

    // reset
    #1;
    chk("rst_read1", m_r1, 0);
    chk("rst_addr1", m_a1, 0);
    chk("rst_addr2_32", s_a2, 0);
    tick(); tick();
    chk("rst_valid", m_vld, 0);
    chk("rst_wreg", m_wreg, 0);
    chk("rst_pc", m_pc, 0);
    chk("rst_valid_32", s_vld, 0);
    rst = 1'b0;

    // ORI $1,$0,0xFFFF
    issue(32'h3401_FFFF, 32'h100);
    #1;
    chk("ori_addr1", m_a1, 0);
    tick();
    chk("ori_aluop", m_aluop, 8'h25);
    chk("ori_alusel", m_alusel, 3'd1);
    chk("ori_wd", m_wd, 1);
    chk("ori_reg2_imm", m_reg2, 64'h0000_0000_0000_FFFF);
    chk("ori_pc", m_pc, 32'h100);

    // OR $2,$1,$1 : ch0 beats ch1
    issue(32'h0021_1025, 32'h104);
    rd1_data = 64'hAAAA; rd2_data = 64'hBBBB;
    set_byp(0, 5'd1, 64'h0000_FFFF, 1'b1);
    set_byp(1, 5'd1, 64'h1234, 1'b1);
    #1;
    chk("or_addr2", m_a2, 1);
    tick();
    chk("byp_ch0_reg1", m_reg1, 64'hFFFF);
    chk("byp_ch0_reg2", m_reg2, 64'hFFFF);
    chk("byp_ch0_reg1_32", s_reg1, 32'hFFFF);
    // ch0 disabled: ch1 on wide, regfile on narrow
    set_byp(0, 5'd1, 64'h0000_FFFF, 1'b0);
    tick();
    chk("byp_ch1_reg1", m_reg1, 64'h1234);
    chk("byp_rf_reg2_32", s_reg2, 32'hBBBB);
    // no matching channel
    set_byp(1, 5'd7, 64'h1234, 1'b1);
    set_byp(2, 5'd9, 64'h5678, 1'b1);
    tick();
    chk("rf_reg1", m_reg1, 64'hAAAA);
    chk("rf_reg2", m_reg2, 64'hBBBB);
    byp_we = '0;

    // OR $5,$0,$0 with ch0 targeting $0
    issue(32'h0000_2825, 32'h108);
    set_byp(0, 5'd0, 64'hDEAD, 1'b1);
    rd1_data = 64'h77; rd2_data = 64'h77;
    tick();
    chk("zero_reg1", m_reg1, 0);
    chk("zero_reg2", m_reg2, 0);
    chk("zero_wd", m_wd, 5);
    byp_we = '0;

    // LW $3,4($0) then OR $4,$3,$0
    issue(32'h8C03_0004, 32'h10C);
    tick();
    chk("lw_is_load", m_ld, 1);
    chk("lw_wd", m_wd, 3);
    chk("lw_wreg", m_wreg, 1);
    chk("lw_aluop", m_aluop, 8'hE3);
    chk("lw_reg2", m_reg2, 64'h4);
    issue(32'h0060_2025, 32'h110);
    rd1_data = 64'h55; rd2_data = 64'h0;
    #1;
    chk("lu_stall_req", m_stl, 1);
    chk("lu_stall_req_32", s_stl, 1);
    tick();
    chk("lu_bubble_valid", m_vld, 0);
    chk("lu_bubble_ld", m_ld, 0);
    chk("lu_bubble_wreg", m_wreg, 0);
    chk("lu_stall_cleared", m_stl, 0);
    tick();
    chk("lu_or_valid", m_vld, 1);
    chk("lu_or_wd", m_wd, 4);
    chk("lu_or_reg1", m_reg1, 64'h55);
    chk("lu_or_pc", m_pc, 32'h110);

    // LW $9,-4($2): sign-extension, then stall suppressed by stall_i
    issue(32'h8C49_FFFC, 32'h114);
    tick();
    chk("lw_sext64", m_reg2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lw_sext32", s_reg2, 32'hFFFF_FFFC);
    issue(32'h0120_2025, 32'h118);
    stall = 1'b1;
    #1;
    chk("stall_masks_req", m_stl, 0);
    stall = 1'b0;
    #1;
    chk("lu_req_rs9", m_stl, 1);
    // reset in the middle of a load-use
    rst = 1'b1;
    #1;
    chk("rst_masks_req", m_stl, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_req", m_stl, 0);
    chk("post_rst_valid", m_vld, 0);

    // MOVZ / MOVN resolved on the forwarded rt value
    issue(32'h00E8_300A, 32'h120);
    rd2_data = 64'h5;
    set_byp(0, 5'd8, 64'h0, 1'b1);
    tick();
    chk("movz_zero_wreg", m_wreg, 1);
    chk("movz_aluop", m_aluop, 8'h0A);
    set_byp(0, 5'd8, 64'h1, 1'b1);
    tick();
    chk("movz_nz_wreg", m_wreg, 0);
    issue(32'h00E8_300B, 32'h124);
    tick();
    chk("movn_nz_wreg", m_wreg, 1);
    byp_we = '0;

    // shift-immediate and LUI immediates
    issue(32'h000B_5143, 32'h128);
    rd2_data = 64'h8000_0000;
    tick();
    chk("sra_reg1_shamt", m_reg1, 64'h5);
    chk("sra_alusel", m_alusel, 3'd2);
    chk("sra_reg2", m_reg2, 64'h8000_0000);
    issue(32'h3C0C_8001, 32'h12C);
    tick();
    chk("lui_reg2", m_reg2, 64'h0000_0000_8001_0000);
    chk("lui_wd", m_wd, 12);

    // SYNC and PREF never write back
    issue(32'h0000_000F, 32'h130);
    tick();
    chk("sync_valid", m_vld, 1);
    chk("sync_wreg", m_wreg, 0);
    issue(32'hCC00_0000, 32'h134);
    tick();
    chk("pref_wreg", m_wreg, 0);
    chk("pref_inv", m_inv, 0);

    // stall holds for 3 cycles while inst changes
    issue(32'h3401_FFFF, 32'h200);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(32'h0000_2825 + 32'(k), 32'h300 + 32'(k));
      tick();
      chk("stall_hold_pc", m_pc, 32'h200);
      chk("stall_hold_wd", m_wd, 1);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", m_vld, 0);
    chk("flush_pc", m_pc, 0);
    chk("flush_wd", m_wd, 0);
    flush = 1'b0; stall = 1'b0;

    // undefined opcode 0x3F
    issue(32'hFC22_1234, 32'h140);
    tick();
    chk("undef_inv", m_inv, 1);
    chk("undef_wreg", m_wreg, 0);
    chk("undef_inv_32", s_inv, 1);

    // no instruction present
    ivld = 1'b0;
    inst = 32'h3401_FFFF;
    tick();
    chk("ivld0_valid", m_vld, 0);
    chk("ivld0_inv", m_inv, 0);
    chk("ivld0_reg2", m_reg2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
Parameters (one per line: name, default, meaning):
REQ-001 DATA_W, 32, operand/data width; SHALL be >= 32.
REQ-002 NUM_BYP, 2, number of write-back bypass channels; index 0 is the youngest stage and has the highest priority.
Ports (one per line: name, direction, width, meaning):
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush_i  in  1  kill the instruction entering ID/EX and load a bubble.
REQ-006 stall_i  in  1  downstream hold; ID/EX register keeps its value.
REQ-007 inst_valid_i  in  1  inst_i/pc_i carry a real instruction.
REQ-008 pc_i  in  32  PC of the instruction being decoded.
REQ-009 inst_i  in  32  instruction word.
REQ-010 reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data.
REQ-011 byp_wreg_i  in  NUM_BYP  per-channel write enable.
REQ-012 byp_wd_i  in  5*NUM_BYP  per-channel destination register.
REQ-013 byp_wdata_i  in  DATA_W*NUM_BYP  per-channel write data.
REQ-014 reg1_read_o, reg2_read_o  out  1 each  combinational regfile read enables.
REQ-015 reg1_addr_o, reg2_addr_o  out  5 each  combinational regfile addresses: inst_i[25:21] and inst_i[20:16].
REQ-016 stall_req_o  out  1  combinational load-use stall request to the fetch stage.
REQ-017 valid_o, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o, inst_invalid_o  out  1/32/8/3/DATA_W/DATA_W/5/1/1/1  registered ID/EX outputs.

Function
REQ-018 Decode SHALL cover OR/AND/XOR/NOR, SLLV/SRLV/SRAV, SLL/SRL/SRA, MFHI/MFLO/MTHI/MTLO, MOVN/MOVZ, SYNC, ORI/ANDI/XORI/LUI, PREF and LW, using the existing aluop/alusel codes plus a new EXE_LW_OP/EXE_RES_LOAD.
REQ-019 ORI/ANDI/XORI immediates SHALL be zero-extended to DATA_W; LUI SHALL use {inst_i[15:0],16'h0} zero-extended to DATA_W; shift-immediate SHALL place inst_i[10:6] in imm[4:0] with the other bits 0.
REQ-020 LW SHALL read port 1 (base), put the sign-extended offset on reg2_o, set wd_o=inst_i[20:16], wreg_o=1 and is_load_o=1.
REQ-021 SYNC and PREF SHALL decode with wreg_o=0.
REQ-022 An operand whose read enable is 0 SHALL take the immediate value.
REQ-023 An enabled operand with address 0 SHALL be 0 and SHALL never be forwarded.
REQ-024 Otherwise the lowest-index channel with byp_wreg_i=1 and a matching byp_wd_i SHALL supply the operand; with no match, the regfile data SHALL be used.
REQ-025 MOVN/MOVZ wreg_o SHALL be based on the forwarded reg2 value (nonzero for MOVN, zero for MOVZ).
REQ-026 An undefined opcode with inst_valid_i=1 SHALL produce a NOP with inst_invalid_o=1 and wreg_o=0.
REQ-027 Load-use: stall_req_o SHALL be 1 when valid_o=1, is_load_o=1, wd_o!=0, and a read port that is enabled for the current instruction addresses wd_o; otherwise stall_req_o SHALL be 0.
REQ-028 Register update SHALL follow this priority: rst > flush_i > stall_i (hold all registers) > stall_req_o (load a bubble) > capture the decode result.
REQ-029 A bubble SHALL be: valid_o=0, aluop NOP, alusel NOP, wreg_o=0, is_load_o=0, inst_invalid_o=0, wd_o=0, reg1_o=reg2_o=0, pc_o=0.
REQ-030 When inst_valid_i=0, a bubble SHALL be captured.
REQ-031 Decode-to-output latency SHALL be exactly 1 cycle.
REQ-032 When flush_i and stall_i are both 1, flush_i SHALL win.
REQ-033 stall_req_o SHALL be 0 while stall_i=1.

Reset
REQ-034 When rst=1 at an edge, all registered outputs SHALL take the bubble value of REQ-029.
REQ-035 While rst=1, reg*_read_o and stall_req_o SHALL be 0 and reg*_addr_o SHALL be 0.
REQ-036 Reset asserted mid-stall or mid-load-use SHALL clear state with no residual stall in the following cycle.

Verification
REQ-037 ORI $1,$0,0xFFFF followed by OR $2,$1,$1 with byp ch0 = ($1, 0x0000FFFF, we=1) and ch1 = ($1, 0x1234, we=1) -> cycle 2 reg1_o=reg2_o=0x0000FFFF (ch0 wins).
REQ-038 LW $3,4($0) followed by ADD-class OR $4,$3,$0 -> stall_req_o=1 for one cycle, bubble captured; next cycle OR is captured with stall_req_o=0.
REQ-039 OR $5,$0,$0 with ch0 = ($0, 0xDEAD, we=1) -> reg1_o=reg2_o=0.
REQ-040 MOVZ $6,$7,$8 with $8 forwarded 0 -> wreg_o=1; with $8 forwarded 1 -> wreg_o=0.
REQ-041 stall_i=1 for 3 cycles with a changing inst_i -> outputs unchanged; flush_i=1 together with stall_i -> bubble next cycle; opcode 0x3F -> inst_invalid_o=1, wreg_o=0.
REQ-042 Run all scenarios at DATA_W=32 and DATA_W=64 with NUM_BYP=1 and NUM_BYP=3; a sign-extended LW offset 0xFFFC SHALL give reg2_o all-ones above bit 15.
